// File: rtl/param_updown_counter_pkg.sv
// Shared encodings for the up/down counter and the timer blocks built on it.
// Direction and bound-mode constants plus the tick outcome type.
package param_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        CN_EVT_NONE = 2'd0,
        CN_EVT_OVF  = 2'd1,
        CN_EVT_UNF  = 2'd2
    } cn_event_e;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter; master drives controls, slave is the counter.
interface param_updown_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  cn_en;
    logic                  cn_dir;
    logic                  cn_load;
    logic [WIDTH-1:0]      cn_load_val;
    logic [WIDTH-1:0]      cn_limit;
    logic [PRESCALE_W-1:0] cn_prescale;
    logic                  cn_clr_flags;
    logic [WIDTH-1:0]      cn_out;
    logic                  cn_zero;
    logic                  cn_tc;
    logic                  cn_ovf;
    logic                  cn_unf;

    modport master (
        output cn_en, cn_dir, cn_load, cn_load_val, cn_limit, cn_prescale, cn_clr_flags,
        input  cn_out, cn_zero, cn_tc, cn_ovf, cn_unf
    );

    modport slave (
        input  cn_en, cn_dir, cn_load, cn_load_val, cn_limit, cn_prescale, cn_clr_flags,
        output cn_out, cn_zero, cn_tc, cn_ovf, cn_unf
    );

endinterface

// File: rtl/param_updown_counter_prescaler.sv
// Clock-enable divider: one tick every cn_prescale+1 enabled cycles, restarted by clr.
module param_updown_counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] cn_prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] pre_reg;
    logic                  at_period;

    assign at_period = (pre_reg == cn_prescale);
    // A load (clr) suppresses the tick even when the period is due.
    assign tick      = en && !clr && at_period;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
        end else if (clr) begin
            pre_reg <= '0;
        end else if (en) begin
            if (at_period) begin
                pre_reg <= '0;
            end else begin
                pre_reg <= pre_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable upper limit, parallel load, prescaled ticks,
// wrap/saturate bounds, terminal-count pulse and sticky overflow/underflow flags.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP       = 1,
    parameter int SATURATE   = 0,
    parameter int PRESCALE_W = 4
) (
    input  logic                  cn_clk,
    input  logic                  cn_rst,
    param_updown_counter_if.slave cn_bus
);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             tc_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic             tick;
    cn_event_e        evt;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] ovf_val;
    logic [WIDTH-1:0] unf_val;

    param_updown_counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_cn_prescaler (
        .clk         (cn_clk),
        .rst         (cn_rst),
        .en          (cn_bus.cn_en),
        .clr         (cn_bus.cn_load),
        .cn_prescale (cn_bus.cn_prescale),
        .tick        (tick)
    );

    // Landing value after a crossed bound depends on the build mode.
    generate
        if (SATURATE == MODE_SAT) begin : g_sat
            assign ovf_val = cn_bus.cn_limit;
            assign unf_val = '0;
        end else begin : g_wrap
            assign ovf_val = '0;
            assign unf_val = cn_bus.cn_limit;
        end
    endgenerate

    // One extra bit so cnt+STEP never aliases below the limit.
    assign up_sum = {1'b0, cnt_reg} + STEP_EXT;

    always_comb begin
        cnt_next = cnt_reg;
        evt      = CN_EVT_NONE;
        if (tick) begin
            if (cn_bus.cn_dir == DIR_UP) begin
                if (up_sum <= {1'b0, cn_bus.cn_limit}) begin
                    cnt_next = up_sum[WIDTH-1:0];
                end else begin
                    cnt_next = ovf_val;
                    evt      = CN_EVT_OVF;
                end
            end else begin
                if ({1'b0, cnt_reg} >= STEP_EXT) begin
                    cnt_next = cnt_reg - STEP_EXT[WIDTH-1:0];
                end else begin
                    cnt_next = unf_val;
                    evt      = CN_EVT_UNF;
                end
            end
        end
    end

    always_ff @(posedge cn_clk) begin
        if (cn_rst) begin
            cnt_reg <= '0;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            cnt_reg <= cn_bus.cn_load ? cn_bus.cn_load_val : cnt_next;
            tc_reg  <= (evt != CN_EVT_NONE);
            // A new event outranks a simultaneous clear.
            ovf_reg <= (evt == CN_EVT_OVF) || (ovf_reg && !cn_bus.cn_clr_flags);
            unf_reg <= (evt == CN_EVT_UNF) || (unf_reg && !cn_bus.cn_clr_flags);
        end
    end

    assign cn_bus.cn_out  = cnt_reg;
    assign cn_bus.cn_zero = (cnt_reg == '0);
    assign cn_bus.cn_tc   = tc_reg;
    assign cn_bus.cn_ovf  = ovf_reg;
    assign cn_bus.cn_unf  = unf_reg;

endmodule
